// File: rtl/axi_wr_sched.sv
// AXI4 write-channel scheduler: routes bursts to the CSR file or DMA FIFO,
// drains malformed bursts and always returns a write response.
module axi_wr_sched #(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [7:0] CSR_LIMIT    = 8'h60,
  parameter logic [3:0] DMA_BASE_NIB = 4'h1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [1:0]              s_axi_awburst,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic                    csr_wr_en,
  output logic [7:0]              csr_wr_addr,
  output logic [31:0]             csr_wr_data,
  output logic [3:0]              csr_wr_strb,
  output logic                    dma_fifo_wr_en,
  output logic [31:0]             dma_fifo_wdata,
  input  logic                    dma_fifo_full,
  output logic                    busy,
  output logic                    err_pulse
);

  typedef enum logic [2:0] {
    IDLE, CSR_DATA, DMA_DATA, DRAIN, RESP
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] INCR   = 2'b01;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  resp_q, resp_d;
  logic        csr_en_q, csr_en_d;
  logic [7:0]  csr_addr_q, csr_addr_d;
  logic [31:0] csr_data_q, csr_data_d;
  logic [3:0]  csr_strb_q, csr_strb_d;
  logic        err_q, err_d;

  logic dma_nib, csr_hit, wready, w_hs, push;

  assign dma_nib = s_axi_awaddr[ADDR_WIDTH-1 -: 4] == DMA_BASE_NIB;
  assign csr_hit = (s_axi_awaddr[ADDR_WIDTH-1:8] == '0) &&
                   (s_axi_awaddr[7:0] < CSR_LIMIT);

  always_comb begin
    wready = 1'b0;
    unique case (state_q)
      CSR_DATA, DRAIN: wready = 1'b1;
      DMA_DATA:        wready = !dma_fifo_full;
      default:         wready = 1'b0;
    endcase
  end

  assign w_hs = s_axi_wvalid && wready;
  assign push = w_hs && (state_q == DMA_DATA);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    csr_en_d   = 1'b0;
    csr_addr_d = csr_addr_q;
    csr_data_d = csr_data_q;
    csr_strb_d = csr_strb_q;
    unique case (state_q)
      IDLE: if (s_axi_awvalid) begin
        addr_d = s_axi_awaddr[7:0];
        len_d  = s_axi_awlen;
        cnt_d  = '0;
        resp_d = OKAY;
        if (s_axi_awsize != 3'b010) begin
          state_d = DRAIN;
          resp_d  = SLVERR;
        end else if (dma_nib) begin
          state_d = (s_axi_awburst == INCR) ? DMA_DATA : DRAIN;
          resp_d  = (s_axi_awburst == INCR) ? OKAY : SLVERR;
        end else if (csr_hit) begin
          state_d = (s_axi_awlen == '0) ? CSR_DATA : DRAIN;
          resp_d  = (s_axi_awlen == '0) ? OKAY : SLVERR;
        end else begin
          state_d = DRAIN;
          resp_d  = DECERR;
        end
      end
      CSR_DATA: if (w_hs) begin
        csr_en_d   = 1'b1;
        csr_addr_d = addr_q;
        csr_data_d = s_axi_wdata[31:0];
        csr_strb_d = s_axi_wstrb[3:0];
        if (s_axi_wlast) begin
          state_d = RESP;
        end else begin
          state_d = DRAIN;
          resp_d  = SLVERR;
        end
      end
      DMA_DATA: if (w_hs) begin
        cnt_d = cnt_q + 8'd1;
        // compare before increment so len=255 never wraps early
        if (s_axi_wlast) begin
          state_d = RESP;
          if (cnt_q != len_q) resp_d = SLVERR;
        end else if (cnt_q == len_q) begin
          state_d = DRAIN;
          resp_d  = SLVERR;
        end
      end
      DRAIN: if (w_hs && s_axi_wlast) state_d = RESP;
      RESP:  if (s_axi_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_d = (state_d == RESP) && (state_q != RESP) && (resp_d != OKAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      resp_q     <= OKAY;
      csr_en_q   <= 1'b0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
      csr_strb_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      csr_en_q   <= csr_en_d;
      csr_addr_q <= csr_addr_d;
      csr_data_q <= csr_data_d;
      csr_strb_q <= csr_strb_d;
      err_q      <= err_d;
    end
  end

  assign s_axi_awready  = state_q == IDLE;
  assign s_axi_wready   = wready;
  assign s_axi_bvalid   = state_q == RESP;
  assign s_axi_bresp    = (state_q == RESP) ? resp_q : OKAY;
  assign csr_wr_en      = csr_en_q;
  assign csr_wr_addr    = csr_addr_q;
  assign csr_wr_data    = csr_data_q;
  assign csr_wr_strb    = csr_strb_q;
  assign dma_fifo_wr_en = push;
  assign dma_fifo_wdata = push ? s_axi_wdata[31:0] : '0;
  assign busy           = state_q != IDLE;
  assign err_pulse      = err_q;

endmodule

// File: tb/tb_axi_wr_sched.sv
// Bench for axi_wr_sched: vector table, hand sequences and a random
// burst mix checked against a transaction-level reference model.
module tb_axi_wr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr;
  logic [1:0]  s_axi_awburst;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic        csr_wr_en;
  logic [7:0]  csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic [3:0]  csr_wr_strb;
  logic        dma_fifo_wr_en;
  logic [31:0] dma_fifo_wdata;
  logic        dma_fifo_full;
  logic        busy;
  logic        err_pulse;

  int checks = 0;
  int errors = 0;

  logic [31:0] push_q[$];
  logic [7:0]  csra_q[$];
  logic [31:0] csrd_q[$];
  logic [3:0]  csrs_q[$];

  axi_wr_sched dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awburst(s_axi_awburst),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr),
    .csr_wr_data(csr_wr_data), .csr_wr_strb(csr_wr_strb),
    .dma_fifo_wr_en(dma_fifo_wr_en), .dma_fifo_wdata(dma_fifo_wdata),
    .dma_fifo_full(dma_fifo_full), .busy(busy), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dma_fifo_wr_en) push_q.push_back(dma_fifo_wdata);
    if (csr_wr_en) begin
      csra_q.push_back(csr_wr_addr);
      csrd_q.push_back(csr_wr_data);
      csrs_q.push_back(csr_wr_strb);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] exp,
                     input string nm);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Outcome of one burst derived straight from the decode/sequencing rules
  function automatic void predict(
    input logic [31:0] a, input logic [1:0] bu, input logic [7:0] ln,
    input logic [2:0] sz, input int nb,
    output logic [1:0] r, output int p, output int c);
    int beats;
    beats = int'(ln) + 1;
    p = 0;
    c = 0;
    if (sz != 3'd2) r = 2'b10;
    else if (a[31:28] == 4'h1) begin
      if (bu == 2'b01) begin
        p = (nb < beats) ? nb : beats;
        r = (nb == beats) ? 2'b00 : 2'b10;
      end else r = 2'b10;
    end else if (a[31:8] == 24'd0 && a[7:0] < 8'h60) begin
      if (ln == 8'd0) begin
        c = 1;
        r = (nb == 1) ? 2'b00 : 2'b10;
      end else r = 2'b10;
    end else r = 2'b11;
  endfunction

  task automatic run_burst(
    input logic [31:0] a, input logic [1:0] bu, input logic [7:0] ln,
    input logic [2:0] sz, input int nb, input int bp,
    input logic [31:0] base, input logic [3:0] sb,
    input logic [1:0] er, input int ep, input int ec, input string nm);
    logic dma;
    logic acc;
    int   lowc;
    int   t;
    dma = (sz == 3'd2) && (a[31:28] == 4'h1) && (bu == 2'b01);
    push_q.delete();
    csra_q.delete();
    csrd_q.delete();
    csrs_q.delete();
    @(posedge clk); #1;
    s_axi_awaddr  = a;
    s_axi_awburst = bu;
    s_axi_awlen   = ln;
    s_axi_awsize  = sz;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_wdata   = base;
    s_axi_wstrb   = sb;
    s_axi_wlast   = (nb == 1);
    dma_fifo_full = 1'b0;
    @(negedge clk);
    chk(s_axi_awready, 1, {nm, "_awready"});
    chk(s_axi_wready, 0, {nm, "_w_before_aw"});
    for (int i = 0; i < nb; i++) begin
      lowc = 0;
      acc  = 1'b0;
      for (int k = 0; k < 60 && !acc; k++) begin
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = base + i;
        s_axi_wlast   = (i == nb - 1);
        case (bp)
          1:       dma_fifo_full = ($urandom_range(0, 2) == 0);
          2:       dma_fifo_full = (i == 2) && (lowc < 5);
          default: dma_fifo_full = 1'b0;
        endcase
        @(negedge clk);
        chk(s_axi_wready, (dma && i <= int'(ln)) ? !dma_fifo_full : 1'b1,
            {nm, "_wready"});
        if (s_axi_wready) acc = 1'b1;
        else lowc++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL %s_w_timeout: beat %0d never accepted", nm, i);
      end
      if (bp == 2 && i == 2) chk(lowc, 5, {nm, "_bp_low_cycles"});
    end
    @(posedge clk); #1;
    s_axi_wvalid  = 1'b0;
    s_axi_wlast   = 1'b0;
    dma_fifo_full = 1'b0;
    @(negedge clk);
    chk(s_axi_bvalid, 1, {nm, "_b_latency"});
    t = 0;
    while (!s_axi_bvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(s_axi_bresp, er, {nm, "_bresp"});
    chk(err_pulse, (er != 2'b00), {nm, "_err_pulse"});
    @(posedge clk); #1;
    @(negedge clk);
    chk(s_axi_bvalid, 1, {nm, "_bvalid_hold"});
    chk(s_axi_bresp, er, {nm, "_bresp_hold"});
    chk(err_pulse, 0, {nm, "_err_one_cycle"});
    @(posedge clk); #1;
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    @(negedge clk);
    chk(s_axi_bvalid, 0, {nm, "_bvalid_drop"});
    chk(s_axi_awready, 1, {nm, "_awready_back"});
    chk(push_q.size(), ep, {nm, "_npush"});
    for (int i = 0; i < push_q.size() && i < ep; i++)
      chk(push_q[i], base + i, {nm, "_push_data"});
    chk(csra_q.size(), ec, {nm, "_ncsr"});
    if (csra_q.size() > 0 && ec > 0) begin
      chk(csra_q[0], a[7:0], {nm, "_csr_addr"});
      chk(csrd_q[0], base, {nm, "_csr_data"});
      chk(csrs_q[0], sb, {nm, "_csr_strb"});
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [2:0]  size;
    int          nb;
    int          bp;
    logic [31:0] base;
    logic [3:0]  strb;
    logic [1:0]  er;
    int          ep;
    int          ec;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic [31:0] ra;
    logic [1:0]  rbu, rr;
    logic [7:0]  rln;
    logic [2:0]  rsz;
    int          rnb, rp, rc;

    vt[0]  = '{32'h51,        2'b01, 8'd0,   3'd2, 1,   0, 32'h1,        4'hF, 2'b00, 0,   1};
    vt[1]  = '{32'hFF,        2'b01, 8'd0,   3'd2, 1,   0, 32'h12345678, 4'hF, 2'b11, 0,   0};
    vt[2]  = '{32'h1000_0000, 2'b01, 8'd3,   3'd2, 4,   0, 32'hDEAD0000, 4'hF, 2'b00, 4,   0};
    vt[3]  = '{32'h1000_0100, 2'b01, 8'd7,   3'd2, 8,   2, 32'hBEEF0000, 4'hF, 2'b00, 8,   0};
    vt[4]  = '{32'h1000_0000, 2'b01, 8'd3,   3'd2, 2,   1, 32'hC0000000, 4'hF, 2'b10, 2,   0};
    vt[5]  = '{32'h1000_0000, 2'b01, 8'd1,   3'd2, 4,   1, 32'hC1000000, 4'hF, 2'b10, 2,   0};
    vt[6]  = '{32'h10,        2'b01, 8'd2,   3'd2, 3,   0, 32'hC2000000, 4'hF, 2'b10, 0,   0};
    vt[7]  = '{32'h1000_0000, 2'b01, 8'd0,   3'd1, 1,   0, 32'hC3000000, 4'hF, 2'b10, 0,   0};
    vt[8]  = '{32'h1000_0000, 2'b00, 8'd2,   3'd2, 3,   0, 32'hC4000000, 4'hF, 2'b10, 0,   0};
    vt[9]  = '{32'h60,        2'b01, 8'd0,   3'd2, 1,   0, 32'hC5000000, 4'hF, 2'b11, 0,   0};
    vt[10] = '{32'h5C,        2'b01, 8'd0,   3'd2, 2,   0, 32'hC6000000, 4'h3, 2'b10, 0,   1};
    vt[11] = '{32'h1000_0000, 2'b01, 8'd255, 3'd2, 256, 1, 32'hD0000000, 4'hF, 2'b00, 256, 0};
    vt[12] = '{32'h2000_0000, 2'b01, 8'd0,   3'd2, 1,   0, 32'hC7000000, 4'hF, 2'b11, 0,   0};
    vt[13] = '{32'h100,       2'b01, 8'd0,   3'd2, 1,   0, 32'hC8000000, 4'hF, 2'b11, 0,   0};
    vt[14] = '{32'h5F,        2'b10, 8'd0,   3'd2, 1,   1, 32'hC9000000, 4'h5, 2'b00, 0,   1};
    vt[15] = '{32'hFF,        2'b01, 8'd0,   3'd0, 1,   0, 32'hCA000000, 4'hF, 2'b10, 0,   0};

    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awburst = '0; s_axi_awlen = '0;
    s_axi_awsize = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; dma_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(s_axi_awready, 1, "rst_awready");
    chk(s_axi_wready, 0, "rst_wready");
    chk(s_axi_bvalid, 0, "rst_bvalid");
    chk(s_axi_bresp, 0, "rst_bresp");
    chk(busy, 0, "rst_busy");
    chk(csr_wr_en, 0, "rst_csr_wr_en");
    chk(dma_fifo_wr_en, 0, "rst_dma_wr_en");
    chk(err_pulse, 0, "rst_err_pulse");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 16; k++)
      run_burst(vt[k].addr, vt[k].burst, vt[k].len, vt[k].size, vt[k].nb,
                vt[k].bp, vt[k].base, vt[k].strb, vt[k].er, vt[k].ep,
                vt[k].ec, $sformatf("vec%0d", k));

    // reset in the middle of a len=7 DMA burst
    push_q.delete();
    @(posedge clk); #1;
    s_axi_awaddr = 32'h1000_0040; s_axi_awburst = 2'b01;
    s_axi_awlen = 8'd7; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hA0; s_axi_wstrb = 4'hF;
    s_axi_wlast = 1'b0;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    @(negedge clk);
    chk(busy, 1, "mid_busy");
    @(posedge clk); #1;
    s_axi_wdata = 32'hA1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(s_axi_awready, 1, "post_rst_awready");
    chk(s_axi_bvalid, 0, "post_rst_bvalid");
    chk(busy, 0, "post_rst_busy");
    @(posedge clk); #1;
    s_axi_wvalid = 1'b1;
    s_axi_wdata = 32'hA2;
    s_axi_wlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk(s_axi_wready, 0, "post_rst_wready");
    end
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    s_axi_wlast = 1'b0;
    @(negedge clk);
    chk(push_q.size(), 2, "rst_npush");
    if (push_q.size() >= 2) begin
      chk(push_q[0], 32'hA0, "rst_push0");
      chk(push_q[1], 32'hA1, "rst_push1");
    end
    run_burst(32'h1000_0000, 2'b01, 8'd2, 3'd2, 3, 0, 32'hE0000000,
              4'hF, 2'b00, 3, 0, "after_rst");

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0:       ra = 32'($urandom_range(0, 32'h7F));
        1:       ra = {4'h1, 28'($urandom)};
        default: ra = $urandom;
      endcase
      rbu = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
      rln = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(0, 6));
      rsz = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd2;
      rnb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9))
                                        : int'(rln) + 1;
      predict(ra, rbu, rln, rsz, rnb, rr, rp, rc);
      run_burst(ra, rbu, rln, rsz, rnb, 1, $urandom, 4'($urandom),
                rr, rp, rc, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_sched.md
Name: axi_wr_sched

Overview:
- AXI4 write-channel controller between the host AXI slave port and the accelerator's internal write targets.
- Decodes each write burst to one of three targets: the CSR file (single-beat writes), the DMA input FIFO (INCR bursts), or none (error).
- Sequences W beats to the selected target with FIFO backpressure.
- Generates BRESP, and drains and flags malformed bursts so the bus never hangs.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; only 32 supported.
- CSR_LIMIT, 8'h60, CSR byte offsets 0..CSR_LIMIT-1 are mapped.
- DMA_BASE_NIB, 4'h1, value of awaddr[31:28] that selects the DMA region.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awburst  in  2  burst type
- s_axi_awlen  in  8  beats minus one
- s_axi_awsize  in  3  bytes per beat (log2)
- s_axi_awvalid  in  1  address valid
- s_axi_awready  out  1  address ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axi_wlast  in  1  last beat
- s_axi_wvalid  in  1  data valid
- s_axi_wready  out  1  data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  response valid
- s_axi_bready  in  1  response ready
- csr_wr_en  out  1  one-cycle CSR write strobe
- csr_wr_addr  out  8  CSR byte offset
- csr_wr_data  out  32  CSR write data
- csr_wr_strb  out  4  CSR byte strobes
- dma_fifo_wr_en  out  1  FIFO push
- dma_fifo_wdata  out  32  FIFO data
- dma_fifo_full  in  1  FIFO full
- busy  out  1  state != IDLE
- err_pulse  out  1  one-cycle pulse when an error response is issued

Behaviour:
- Reset (rst=1 at posedge) forces state IDLE.
  - All outputs 0, except s_axi_awready=1 in IDLE.
  - Latched addr, len and beat counter are cleared.
  - Reset mid-burst abandons the burst: no BRESP, no further FIFO pushes.
- States: IDLE, CSR_DATA, DMA_DATA, DRAIN, RESP.
- IDLE:
  - s_axi_awready=1.
  - On an AW handshake, latch awaddr and awlen, then decode in priority order:
    1. awsize!=3'b010 -> DRAIN, resp=SLVERR(2'b10).
    2. awaddr[31:28]==DMA_BASE_NIB and awburst==INCR -> DMA_DATA, resp=OKAY.
    3. awaddr[31:28]==DMA_BASE_NIB with any other burst type -> DRAIN, SLVERR.
    4. awaddr[31:8]==0 and awaddr[7:0]<CSR_LIMIT: awlen==0 -> CSR_DATA, OKAY; awlen!=0 -> DRAIN, SLVERR.
    5. Anything else -> DRAIN, resp=DECERR(2'b11).
- s_axi_wready is 0 in IDLE and RESP. W beats presented before the AW handshake are not accepted.
- CSR_DATA:
  - wready=1.
  - On a W handshake, register addr/data/strb; csr_wr_en=1 for exactly the following cycle.
  - If wlast=0, still commit the beat, set resp=SLVERR and go to DRAIN. Otherwise go to RESP.
- DMA_DATA:
  - wready = !dma_fifo_full (combinational).
  - dma_fifo_wr_en = wvalid & wready, with dma_fifo_wdata = wdata, in the same cycle.
  - Beat counter increments per handshake.
  - wlast with count==len: push the beat, go to RESP.
  - wlast with count<len (early): push the beat, resp=SLVERR, go to RESP.
  - count==len with wlast=0 (long burst): push the beat, resp=SLVERR, go to DRAIN.
  - wstrb is ignored for DMA beats.
- DRAIN:
  - wready=1; beats are consumed and never forwarded.
  - Exit to RESP on the wlast handshake.
- RESP:
  - bvalid=1 and bresp held stable until bready.
  - On the handshake, return to IDLE. awready is reasserted the next cycle, so back-to-back bursts cost 1 idle cycle.
- err_pulse=1 on the first RESP cycle when bresp!=OKAY.
- Latency:
  - AW handshake to wready: 1 cycle.
  - Final W handshake to bvalid: 1 cycle.
  - CSR W handshake to csr_wr_en: 1 cycle.
- Beat counter is 8 bits; len 255 (256 beats) must not wrap early.

Test Plan:
- CSR write: awaddr=0x51, len=0, wdata=0x1, wlast=1 -> csr_wr_en one cycle with addr 0x51, data 0x1, strb 0xF; BRESP=00; no FIFO push.
- Unmapped address: awaddr=0xFF, one beat 0x12345678 -> no csr_wr_en, no push; BRESP=11; err_pulse=1 for one cycle.
- DMA burst: awaddr=0x1000_0000, INCR, len=3, data 0xDEAD0000..3 -> 4 pushes in order; BRESP=00 one cycle after the 4th beat.
- DMA backpressure: dma_fifo_full high for 5 cycles mid-burst -> wready low exactly those cycles; no dropped or duplicated push; BRESP=00.
- Malformed bursts:
  - len=3 with wlast on beat 1 -> 2 pushes, BRESP=10.
  - len=1 with wlast on beat 3 -> 2 pushes, 2 drained beats, BRESP=10.
  - CSR awlen=2 -> no csr_wr_en, BRESP=10.
- Reset: rst asserted after beat 1 of a len=7 DMA burst -> next cycle state IDLE, awready=1, bvalid=0; a following burst completes normally with BRESP=00.
